mem_access: RTL and testbench
=============================

# mem_access

Load/store unit for the stage after execute. It takes the effective address produced by execute (`alu_result`), the store operand, and the ALU code. It runs one data-memory transaction over a request/grant/response handshake, then returns aligned, sign- or zero-extended load data to writeback. While a transaction is in flight it drives a stall so the pipeline holds.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute presents an op this cycle.
- `alucode` in 6: `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW` from `define.vh`; any other code is not a memory op.
- `alu_result` in 32: effective byte address.
- `store_data` in 32: rs2 value.
- `req_ready` out 1: unit is IDLE and accepts.
- `stall` out 1: high in every non-IDLE state.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32, `dmem_wstrb` out 4: memory request.
- `dmem_gnt` in 1: memory accepted the request.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.
- `done` out 1: one-cycle pulse when the op completes.
- `load_data` out 32: valid when `done` is high and the op was a load.
- `misaligned` out 1: pulses with `done` when the access was misaligned.

## Operation
- States are IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` with a memory `alucode`: latch alucode, address, store data; compute misalignment; go to REQ, or to DONE if misaligned.
  - Non-memory codes are ignored and the unit stays IDLE.
- **REQ**
  - `dmem_req`=1; all `dmem_*` outputs come from latched registers and stay stable until `dmem_gnt`.
  - Store with gnt → DONE.
  - Load with gnt and no rvalid → WAIT.
  - Load with gnt and rvalid in the same cycle → capture and go to DONE.
- **WAIT**
  - `dmem_req`=0.
  - On `dmem_rvalid`, capture the formatted `dmem_rdata` and go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
  - A new request is accepted no earlier than the following IDLE cycle.
- **Address and strobes**
  - `dmem_addr` = {addr[31:2], 2'b00}.
  - Byte: wstrb = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - Half: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = half replicated ×2.
  - Word: wstrb = 4'b1111.
  - For loads, wstrb is still driven from the same size rule; memory ignores it when `dmem_we`=0.
- **Load formatting**
  - Select byte or half by addr[1:0].
  - LB and LH sign-extend from bit 7 and bit 15; LBU and LHU zero-extend.
- **Misalignment**
  - Half with addr[0]=1, or word with addr[1:0]≠0.
  - No memory access is made; `misaligned`=1 and `load_data`=0 during DONE.
- **Reset**
  - Any state → IDLE on the next edge; the latched op is dropped.
  - A late `dmem_rvalid` arriving in IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `dmem_req`, `dmem_we`, `done`, `misaligned`, `stall` = 0.
  - `req_ready` = 1.
  - `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `load_data` = 0.
- All outputs are registered or decoded from the state register; there is no combinational path from `dmem_*` inputs to `dmem_*` outputs.
- Minimum latencies, measured from the accept edge:
  - Store with immediate gnt: 2 cycles.
  - Load with gnt and rvalid together: 2 cycles.
  - Load with rvalid one cycle after gnt: 3 cycles.
  - Misaligned op: 1 cycle.
- `load_data` holds its value after DONE until the next load completes.

## Structure
- Add to `define.vh`:
  - state encodings `MA_IDLE/MA_REQ/MA_WAIT/MA_DONE` (2 bits);
  - size codes `MEM_B/MEM_H/MEM_W`.
  - The existing `ALU_L*/S*` codes are reused.
- One sub-module, `load_align`: combinational, inputs rdata[31:0], addr[1:0], size, unsigned; output the 32-bit formatted value.
- The size, strobe and replication decode stays in `mem_access` as functions.

## Test plan
- **SW word store:** SW addr 0x1000, data 0xDEADBEEF, gnt on first REQ cycle → `dmem_we`=1, addr 0x1000, wstrb 4'b1111; `done` 2 cycles after accept; `misaligned`=0.
- **LB sign extension:** LB addr 0x2003, rdata 0x80FF_FF7F, rvalid 1 cycle after gnt → `load_data` 0xFFFF_FF80 with `done` at cycle 3; LBU of the same data → 0x0000_0080.
- **Grant stall:** SH addr 0x0006, data 0x1234, gnt withheld 3 cycles → `dmem_req`, addr 0x0004, wstrb 4'b1100 and wdata 0x1234_1234 all stable until gnt; `stall` high throughout.
- **Misaligned word:** LW addr 0x0002 → no `dmem_req` ever; next cycle `done`=1, `misaligned`=1, `load_data`=0.
- **Reset mid-load:** LW accepted, `rst` asserted during WAIT, rvalid arrives after reset → state IDLE, `done` never pulses, `load_data` stays 0.
- **Non-memory op:** `req_valid` with `ALU_ADD` → unit stays IDLE; `req_ready`=1, `stall`=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared codes for the load/store stage: ALU op codes for
//               memory ops, FSM state encodings and access-size codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  // ALU op codes (memory subset plus one arithmetic code used as a non-memory op)
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  // Load/store FSM state encodings
  localparam logic [1:0] MA_IDLE = 2'd0;
  localparam logic [1:0] MA_REQ  = 2'd1;
  localparam logic [1:0] MA_WAIT = 2'd2;
  localparam logic [1:0] MA_DONE = 2'd3;

  // Access size codes
  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half/word out of a 32-bit memory
//               read word and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_size_t   size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and half out of the read word
  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected field to the full register width
  always_comb begin
    data = rdata;
    case (size)
      MEM_B:   data = zero_ext ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      MEM_H:   data = zero_ext ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Load/store unit. Accepts one memory op from execute, runs a
//               request/grant/response transaction on the data-memory port,
//               and returns formatted load data. Stalls the pipeline while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  alucode,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        req_ready,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned
);

  // --------------------------------------------------------------------------
  // Op decode helpers
  // --------------------------------------------------------------------------
  function automatic logic is_mem_op(input logic [5:0] code);
    case (code)
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
      ALU_SB, ALU_SH, ALU_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] code);
    case (code)
      ALU_SB, ALU_SH, ALU_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_zext_op(input logic [5:0] code);
    case (code)
      ALU_LBU, ALU_LHU: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic mem_size_t size_of(input logic [5:0] code);
    case (code)
      ALU_LB, ALU_LBU, ALU_SB: return MEM_B;
      ALU_LH, ALU_LHU, ALU_SH: return MEM_H;
      default:                 return MEM_W;
    endcase
  endfunction

  function automatic logic [3:0] strobe_of(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MEM_B:   return 4'b0001 << lo;
      MEM_H:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Sub-word stores replicate the operand so any enabled lane carries it
  function automatic logic [31:0] replicate(input mem_size_t size, input logic [31:0] d);
    case (size)
      MEM_B:   return {4{d[7:0]}};
      MEM_H:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MEM_H:   return lo[0];
      MEM_W:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State and latched op
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic        r_we;
  mem_size_t   r_size;
  logic        r_zext;
  logic [1:0]  r_addr_lo;
  logic        r_mis;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_wstrb;
  logic [31:0] r_load_data;

  logic        w_accept;
  logic        w_new_mis;
  logic        w_capture;
  logic [31:0] w_aligned;
  mem_size_t   w_new_size;

  assign w_new_size = size_of(alucode);
  assign w_new_mis  = is_misaligned(w_new_size, alu_result[1:0]);
  assign w_accept   = (r_state == MA_IDLE) && req_valid && is_mem_op(alucode);

  // A load completes either on the grant cycle itself or later in WAIT
  assign w_capture  = dmem_rvalid && !r_we &&
                      (((r_state == MA_REQ) && dmem_gnt) || (r_state == MA_WAIT));

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .addr     (r_addr_lo),
    .size     (r_size),
    .zero_ext (r_zext),
    .data     (w_aligned)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MA_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MA_IDLE: begin
        if (w_accept) begin
          w_state_next = w_new_mis ? MA_DONE : MA_REQ;
        end
      end
      MA_REQ: begin
        if (dmem_gnt) begin
          if (r_we || dmem_rvalid) begin
            w_state_next = MA_DONE;
          end else begin
            w_state_next = MA_WAIT;
          end
        end
      end
      MA_WAIT: begin
        if (dmem_rvalid) begin
          w_state_next = MA_DONE;
        end
      end
      default: w_state_next = MA_IDLE;
    endcase
  end

  // Status and handshake outputs decoded from the state register
  always_comb begin
    req_ready  = (r_state == MA_IDLE);
    stall      = (r_state != MA_IDLE);
    dmem_req   = (r_state == MA_REQ);
    done       = (r_state == MA_DONE);
    misaligned = (r_state == MA_DONE) && r_mis;
  end

  // Latch the op at accept and capture formatted load data on response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_size       <= MEM_W;
      r_zext       <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_mis        <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_wstrb <= 4'd0;
      r_load_data  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we         <= is_store_op(alucode);
        r_size       <= w_new_size;
        r_zext       <= is_zext_op(alucode);
        r_addr_lo    <= alu_result[1:0];
        r_mis        <= w_new_mis;
        r_dmem_addr  <= {alu_result[31:2], 2'b00};
        r_dmem_wdata <= replicate(w_new_size, store_data);
        r_dmem_wstrb <= strobe_of(w_new_size, alu_result[1:0]);
        // A misaligned op reports zero load data during its DONE cycle
        if (w_new_mis) begin
          r_load_data <= 32'd0;
        end
      end
      if (w_capture) begin
        r_load_data <= w_aligned;
      end
    end
  end

  assign dmem_we    = r_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign dmem_wstrb = r_dmem_wstrb;
  assign load_data  = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for the mem_access load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [5:0]  alucode;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        req_ready;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .alucode     (alucode),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .req_ready   (req_ready),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .done        (done),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] data);
    req_valid  = 1'b1;
    alucode    = code;
    alu_result = addr;
    store_data = data;
    step();
    req_valid  = 1'b0;
    alucode    = ALU_ADD;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (dmem_req !== 1'b0)    begin errors++; $display("FAIL reset_dmem_req: got %b want 0", dmem_req); end
    checks++; if (dmem_we !== 1'b0)     begin errors++; $display("FAIL reset_dmem_we: got %b want 0", dmem_we); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (misaligned !== 1'b0)  begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
    checks++; if (dmem_addr !== 32'd0)  begin errors++; $display("FAIL reset_dmem_addr: got %h want 0", dmem_addr); end
    checks++; if (dmem_wdata !== 32'd0) begin errors++; $display("FAIL reset_dmem_wdata: got %h want 0", dmem_wdata); end
    checks++; if (dmem_wstrb !== 4'd0)  begin errors++; $display("FAIL reset_dmem_wstrb: got %h want 0", dmem_wstrb); end
    checks++; if (load_data !== 32'd0)  begin errors++; $display("FAIL reset_load_data: got %h want 0", load_data); end
  endtask

  task automatic test_sw_store();
    issue(ALU_SW, 32'h0000_1000, 32'hDEAD_BEEF);
    checks++; if (dmem_req !== 1'b1)            begin errors++; $display("FAIL sw_req: got %b want 1", dmem_req); end
    checks++; if (dmem_we !== 1'b1)             begin errors++; $display("FAIL sw_we: got %b want 1", dmem_we); end
    checks++; if (dmem_addr !== 32'h0000_1000)  begin errors++; $display("FAIL sw_addr: got %h want 00001000", dmem_addr); end
    checks++; if (dmem_wstrb !== 4'b1111)       begin errors++; $display("FAIL sw_wstrb: got %b want 1111", dmem_wstrb); end
    checks++; if (dmem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", dmem_wdata); end
    checks++; if (done !== 1'b0)                begin errors++; $display("FAIL sw_done_early: got %b want 0", done); end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    checks++; if (done !== 1'b1)       begin errors++; $display("FAIL sw_done: got %b want 1", done); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL sw_misaligned: got %b want 0", misaligned); end
    checks++; if (dmem_req !== 1'b0)   begin errors++; $display("FAIL sw_req_in_done: got %b want 0", dmem_req); end
    step();
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL sw_done_pulse: got %b want 0", done); end
    checks++; if (req_ready !== 1'b1)  begin errors++; $display("FAIL sw_back_idle: got %b want 1", req_ready); end
  endtask

  // Table of loads: code, address, read word, rvalid delay after gnt, result
  task automatic test_load_format();
    logic [5:0]  codes [6] = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_LB};
    logic [31:0] addrs [6] = '{32'h2003, 32'h2003, 32'h0002, 32'h0000, 32'h0010, 32'h0001};
    logic [31:0] rdat  [6] = '{32'h80FF_FF7F, 32'h80FF_FF7F, 32'h8001_1234, 32'h8001_1234,
                               32'hCAFE_F00D, 32'h0000_7F00};
    int          dly   [6] = '{1, 0, 1, 0, 2, 0};
    logic [31:0] exp   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_1234,
                               32'hCAFE_F00D, 32'h0000_007F};
    logic [3:0]  strb  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      issue(codes[i], addrs[i], 32'h5555_5555);
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL load%0d_we: got %b want 0", i, dmem_we); end
      checks++; if (dmem_addr !== {addrs[i][31:2], 2'b00})
        begin errors++; $display("FAIL load%0d_addr: got %h want %h", i, dmem_addr, {addrs[i][31:2], 2'b00}); end
      checks++; if (dmem_wstrb !== strb[i]) begin errors++; $display("FAIL load%0d_wstrb: got %b want %b", i, dmem_wstrb, strb[i]); end
      dmem_gnt = 1'b1;
      if (dly[i] == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdat[i];
      end
      step();
      dmem_gnt = 1'b0;
      for (int d = 1; d <= dly[i]; d++) begin
        checks++; if (done !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b1)
          begin errors++; $display("FAIL load%0d_wait: got done=%b req=%b stall=%b want 0 0 1", i, done, dmem_req, stall); end
        if (d == dly[i]) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rdat[i];
        end
        step();
      end
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL load%0d_done: got %b want 1", i, done); end
      checks++; if (load_data !== exp[i]) begin errors++; $display("FAIL load%0d_data: got %h want %h", i, load_data, exp[i]); end
      step();
      checks++; if (done !== 1'b0 || load_data !== exp[i])
        begin errors++; $display("FAIL load%0d_hold: got done=%b data=%h want 0 %h", i, done, load_data, exp[i]); end
    end
  endtask

  task automatic test_grant_stall();
    issue(ALU_SH, 32'h0000_0006, 32'h0000_1234);
    for (int c = 0; c < 3; c++) begin
      checks++; if (dmem_req !== 1'b1 || stall !== 1'b1 || dmem_we !== 1'b1)
        begin errors++; $display("FAIL sh_hold%0d_ctl: got req=%b stall=%b we=%b want 1 1 1", c, dmem_req, stall, dmem_we); end
      checks++; if (dmem_addr !== 32'h0000_0004 || dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'h1234_1234)
        begin errors++; $display("FAIL sh_hold%0d_bus: got addr=%h strb=%b wdata=%h want 00000004 1100 12341234", c, dmem_addr, dmem_wstrb, dmem_wdata); end
      step();
    end
    checks++; if (dmem_req !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL sh_pre_gnt: got req=%b done=%b want 1 0", dmem_req, done); end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    checks++; if (done !== 1'b1 || misaligned !== 1'b0)
      begin errors++; $display("FAIL sh_done: got done=%b mis=%b want 1 0", done, misaligned); end
    step();
  endtask

  task automatic test_misaligned();
    // load_data is non-zero from the previous loads, so zeroing is observable
    issue(ALU_LW, 32'h0000_0002, 32'h0);
    checks++; if (done !== 1'b1 || misaligned !== 1'b1)
      begin errors++; $display("FAIL mis_lw_flags: got done=%b mis=%b want 1 1", done, misaligned); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL mis_lw_data: got %h want 0", load_data); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_lw_req: got %b want 0", dmem_req); end
    step();
    checks++; if (done !== 1'b0 || misaligned !== 1'b0 || dmem_req !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL mis_lw_after: got done=%b mis=%b req=%b rdy=%b want 0 0 0 1", done, misaligned, dmem_req, req_ready); end
    issue(ALU_SH, 32'h0000_0001, 32'hFFFF);
    checks++; if (done !== 1'b1 || misaligned !== 1'b1 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL mis_sh: got done=%b mis=%b req=%b want 1 1 0", done, misaligned, dmem_req); end
    step();
  endtask

  task automatic test_reset_mid_load();
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(ALU_LW, 32'h0000_0100, 32'h0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    checks++; if (stall !== 1'b1 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL rstmid_wait: got stall=%b req=%b want 1 0", stall, dmem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || stall !== 1'b0)
      begin errors++; $display("FAIL rstmid_idle: got rdy=%b stall=%b want 1 0", req_ready, stall); end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    checks++; if (done !== 1'b0 || load_data !== 32'd0)
      begin errors++; $display("FAIL rstmid_late_rvalid: got done=%b data=%h want 0 0", done, load_data); end
    step();
    checks++; if (done !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_after: got done=%b rdy=%b want 0 1", done, req_ready); end
  endtask

  task automatic test_non_mem();
    issue(ALU_ADD, 32'h0000_1000, 32'h1);
    checks++; if (req_ready !== 1'b1 || stall !== 1'b0 || dmem_req !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL nonmem: got rdy=%b stall=%b req=%b done=%b want 1 0 0 0", req_ready, stall, dmem_req, done); end
    issue(6'd63, 32'h0000_1000, 32'h1);
    checks++; if (req_ready !== 1'b1 || stall !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL nonmem63: got rdy=%b stall=%b req=%b want 1 0 0", req_ready, stall, dmem_req); end
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    alucode     = ALU_ADD;
    alu_result  = 32'h0;
    store_data  = 32'h0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    #1;
    test_reset();
    test_sw_store();
    test_load_format();
    test_grant_stall();
    test_misaligned();
    test_reset_mid_load();
    test_non_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
